// File: rtl/uart_cmd_parser_if.sv
// Handshake bundle around uart_cmd_parser: the receive byte stream, the
// transmit byte stream and the single-beat 32-bit memory bus.
// The master modport is the parser's view; the slave modport is the
// environment (RX FIFO, transmitter, memory) driving it.
interface uart_cmd_parser_if;
    // Receive byte stream (from the UART RX FIFO)
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    // Transmit byte stream (towards the UART transmitter)
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    // Memory bus request / response
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    modport master (
        input  in_data, in_valid, out_ready, mem_req_ready, mem_rsp_valid, mem_rdata,
        output in_ready, out_data, out_valid, mem_req_valid, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_data, in_valid, out_ready, mem_req_ready, mem_rsp_valid, mem_rdata,
        input  in_ready, out_data, out_valid, mem_req_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns a received byte stream into single 32-bit memory
// transactions and answers with ACK, NAK or the read data bytes.
//   Write packet: 'W' (8'h57), addr[4], data[4]  -> ACK_BYTE
//   Read packet : 'R' (8'h52), addr[4]           -> rdata[7:0] .. rdata[31:24]
//   Other opcode: consumed                       -> NAK_BYTE
// Multi-byte fields are little-endian.
// Optional build macro UART_CMD_TIMEOUT_EN: abandon a partial packet with a
// NAK when no byte arrives for TIMEOUT_CYCLES cycles in ADDR or WDATA.
module uart_cmd_parser #(
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic                clk,
    input  logic                nrst,
    uart_cmd_parser_if.master   bus
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        REQ,
        WAIT_RSP,
        SEND
    } state_e;

    state_e      state_q;
    logic [1:0]  byte_cnt_q;     // byte index within the current 4-byte field
    logic [2:0]  send_cnt_q;     // bytes still to transmit (1..4)
    logic [31:0] tx_shift_q;     // outgoing bytes, current byte in [7:0]
    logic        in_ready_q;
    logic        out_valid_q;
    logic        mem_req_valid_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
`ifdef UART_CMD_TIMEOUT_EN
    logic [31:0] timeout_q;      // idle cycles since the last accepted byte
`endif

    logic in_fire;
    logic out_fire;
    logic req_fire;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;
    assign req_fire = mem_req_valid_q & bus.mem_req_ready;

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = tx_shift_q[7:0];
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;

    // Packet FSM with all outputs registered; every transition also sets the
    // handshake outputs for the state being entered.
    // NOTE: non-blocking assignments only, so every branch sees the values
    // from before this edge and the later timeout override wins cleanly.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q         <= IDLE;
            byte_cnt_q      <= 2'd0;
            send_cnt_q      <= 3'd0;
            tx_shift_q      <= 32'd0;
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 32'd0;
            mem_wdata_q     <= 32'd0;
`ifdef UART_CMD_TIMEOUT_EN
            timeout_q       <= 32'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        byte_cnt_q <= 2'd0;
                        if (bus.in_data == OP_WRITE) begin
                            mem_we_q <= 1'b1;
                            state_q  <= ADDR;
                        end else if (bus.in_data == OP_READ) begin
                            mem_we_q <= 1'b0;
                            state_q  <= ADDR;
                        end else begin
                            // Unknown opcode: swallow it and answer NAK.
                            tx_shift_q  <= {24'd0, NAK_BYTE};
                            send_cnt_q  <= 3'd1;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= SEND;
                        end
                    end
                end

                ADDR: begin
                    if (in_fire) begin
                        mem_addr_q[{byte_cnt_q, 3'b000} +: 8] <= bus.in_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_q <= 2'd0;
                            if (mem_we_q) begin
                                state_q <= WDATA;
                            end else begin
                                in_ready_q      <= 1'b0;
                                mem_req_valid_q <= 1'b1;
                                state_q         <= REQ;
                            end
                        end
                    end
                end

                WDATA: begin
                    if (in_fire) begin
                        mem_wdata_q[{byte_cnt_q, 3'b000} +: 8] <= bus.in_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_q      <= 2'd0;
                            in_ready_q      <= 1'b0;
                            mem_req_valid_q <= 1'b1;
                            state_q         <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (req_fire) begin
                        mem_req_valid_q <= 1'b0;
                        if (mem_we_q) begin
                            tx_shift_q  <= {24'd0, ACK_BYTE};
                            send_cnt_q  <= 3'd1;
                            out_valid_q <= 1'b1;
                            state_q     <= SEND;
                        end else begin
                            state_q <= WAIT_RSP;
                        end
                    end
                end

                WAIT_RSP: begin
                    if (bus.mem_rsp_valid) begin
                        tx_shift_q  <= bus.mem_rdata;
                        send_cnt_q  <= 3'd4;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end

                SEND: begin
                    if (out_fire) begin
                        tx_shift_q <= {8'd0, tx_shift_q[31:8]};
                        send_cnt_q <= send_cnt_q - 3'd1;
                        if (send_cnt_q == 3'd1) begin
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase

`ifdef UART_CMD_TIMEOUT_EN
            // Inter-byte gap watchdog: overrides the case above when a
            // partial packet has been idle for TIMEOUT_CYCLES cycles.
            if ((state_q == ADDR || state_q == WDATA) && !in_fire) begin
                if (timeout_q >= TIMEOUT_CYCLES - 32'd1) begin
                    timeout_q   <= 32'd0;
                    byte_cnt_q  <= 2'd0;
                    tx_shift_q  <= {24'd0, NAK_BYTE};
                    send_cnt_q  <= 3'd1;
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b0;
                    state_q     <= SEND;
                end else begin
                    timeout_q <= timeout_q + 32'd1;
                end
            end else begin
                timeout_q <= 32'd0;
            end
`endif
        end
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Byte-stream command decoder sitting directly downstream of the UART receive FIFO and upstream of the UART transmitter's byte stream.
- Assembles read/write command packets from received bytes and issues single 32-bit memory-bus transactions.
- Returns an ACK byte, a NAK byte or read data as a byte stream for transmission.
- Turns the serial link into a host debug/load port.

Parameters:
- ACK_BYTE, 8'h06, byte emitted after a completed write
- NAK_BYTE, 8'h15, byte emitted on an unknown opcode (or a timeout, see Optional Feature)
- TIMEOUT_CYCLES, 32'd1000000, maximum idle gap in cycles between bytes of one packet (used only with the optional feature)

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- in_data  in  8  received byte
- in_valid  in  1  received byte valid
- in_ready  out  1  parser accepts a byte
- out_data  out  8  byte to transmit
- out_valid  out  1  out_data valid
- out_ready  in  1  transmitter accepts a byte
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts the request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  request address
- mem_wdata  out  32  write data
- mem_rsp_valid  in  1  read data valid, single-cycle pulse
- mem_rdata  in  32  read data

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on nrst.
  - Reset forces state IDLE.
  - in_ready=1, out_valid=0, out_data=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Byte counter and timeout counter are cleared.
  - Reset mid-packet or mid-transaction abandons it; no byte is emitted.
- Handshakes: a transfer occurs when valid&&ready on a rising edge.
  - A producer holds valid and data stable until the transfer completes.
  - in_ready=1 only in IDLE, ADDR and WDATA.
- Packet formats (multi-byte fields little-endian, byte0 = bits 7:0):
  - Write: 8'h57 ('W'), addr[4], data[4].
  - Read: 8'h52 ('R'), addr[4].
- State IDLE: on byte accept:
  - 8'h57: set mem_we=1, go ADDR.
  - 8'h52: set mem_we=0, go ADDR.
  - Any other value: load NAK_BYTE and go SEND; the byte is consumed.
- State ADDR: accept 4 bytes into mem_addr.
  - After the 4th: go WDATA if writing, otherwise REQ.
- State WDATA: accept 4 bytes into mem_wdata, then go REQ.
- State REQ: mem_req_valid=1, with mem_addr, mem_wdata and mem_we stable.
  - mem_req_valid rises the cycle after the last packet byte is accepted.
  - On the handshake, mem_req_valid drops the next cycle.
  - A write loads ACK_BYTE and goes SEND; a read goes WAIT_RSP.
- State WAIT_RSP: on mem_rsp_valid, capture mem_rdata into a 32-bit shift register.
  - Set send count=4 and go SEND.
  - mem_rsp_valid is ignored in every other state.
- State SEND: out_valid=1 with out_data = current byte.
  - On each out_ready handshake, shift to the next byte and decrement the count.
  - After the last byte, drop out_valid and go IDLE.
  - ACK/NAK is a count of 1.
  - out_valid rises the cycle after the write handshake or rsp pulse; back-to-back bytes are sent with no bubble while out_ready=1.
- Backpressure:
  - A stalled out_ready stalls the parser, and in_ready stays 0 in SEND.
  - The receive FIFO absorbs incoming bytes meanwhile.
- The byte counter is 2 bits, wraps 3→0 at the field end, and is cleared on every state change.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- When defined, in ADDR or WDATA a counter increments every cycle without a byte accept and clears on each accept.
  - When it reaches TIMEOUT_CYCLES, the partial packet is discarded, NAK_BYTE is loaded, and the state goes SEND.
- When undefined, there is no counter and the parser waits indefinitely for packet bytes; TIMEOUT_CYCLES is unused.

Test Plan:
- Write 'W',78,56,34,12,EF,BE,AD,DE with mem_req_ready=1 → one request: we=1, addr=32'h12345678, wdata=32'hDEADBEEF; then out byte 8'h06.
- Read 'R',00,10,00,00; rsp mem_rdata=32'hCAFEBABE 3 cycles after the handshake → request we=0, addr=32'h00001000; out bytes BE,BA,FE,CA in order.
- Opcode 8'h41 → out byte 8'h15, state IDLE; a following valid 'R' packet then decodes correctly.
- out_ready=0 for 20 cycles during a read reply → out_valid held with out_data=8'hBE stable, in_ready=0 throughout; all 4 bytes arrive after release.
- mem_req_ready held low 10 cycles → mem_req_valid, addr and wdata stable for the whole wait; a single transaction is issued.
- Assert nrst low mid-ADDR after 2 address bytes → outputs return to reset values immediately; a subsequent full write succeeds. With UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100, a 'W' followed by a 150-cycle gap → NAK 8'h15 and no bus request.
